scan_shift_ctrl: RTL and testbench

SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

---
 rtl/scan_shift_ctrl.sv | 126 ++++++++++++
 tb/tb_scan_shift_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scan_shift_ctrl                                              |
// | Description : Scan chain shift/capture controller. Serially loads a        |
// |               stimulus pattern (LSB first) while unloading the previous    |
// |               chain contents, optionally pulses a one-cycle functional     |
// |               capture, then signals completion with a one-cycle done.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module scan_shift_ctrl #(
    parameter int CHAIN_LEN = 8            // chain length in cells, 2..32
) (
    input  logic                 CLK,
    input  logic                 CoreIN_RESET,
    input  logic                 start,
    input  logic                 capture_en,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    output logic                 scan_out,
    input  logic                 scan_in,
    output logic                 se,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
);

    // Counter must hold CHAIN_LEN itself so it never wraps mid-operation.
    localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cap_q, cap_d;
    logic                 se_q, se_d;
    logic                 scan_out_q, scan_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state, datapath and output decode. Outputs are decoded from the
    // next state so that the registered outputs line up with the state they
    // describe.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = pattern_in;
                    cap_d   = capture_en;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Pattern leaves from bit 0; response fills from the top so
                // the first bit received ends up in bit 0.
                shift_d = shift_q >> 1;
                resp_d  = {scan_in, resp_q[CHAIN_LEN-1:1]};
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = cap_q ? CAPTURE : DONE;
                end
            end
            CAPTURE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        se_d       = (state_d == SHIFT);
        scan_out_d = (state_d == SHIFT) ? shift_d[0] : 1'b0;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (CoreIN_RESET) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            resp_q     <= '0;
            cnt_q      <= '0;
            cap_q      <= 1'b0;
            se_q       <= 1'b0;
            scan_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            se_q       <= se_d;
            scan_out_q <= scan_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign se       = se_q;
    assign scan_out = scan_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_scan_shift_ctrl                                           |
// | Description : Directed self-checking bench for scan_shift_ctrl driving an  |
// |               8-cell scan chain model whose functional inputs are 0.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_scan_shift_ctrl;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         CoreIN_RESET;
    logic         start;
    logic         capture_en;
    logic [N-1:0] pattern_in;
    logic         scan_out;
    logic         scan_in;
    logic         se;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic [N-1:0] chain_q;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    scan_shift_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK          (CLK),
        .CoreIN_RESET (CoreIN_RESET),
        .start        (start),
        .capture_en   (capture_en),
        .pattern_in   (pattern_in),
        .scan_out     (scan_out),
        .scan_in      (scan_in),
        .se           (se),
        .busy         (busy),
        .done         (done),
        .response     (response)
    );

    always #5 CLK = ~CLK;

    // Scan chain: shifts when se=1, loads functional D=0 on the capture cycle.
    always @(posedge CLK) begin
        if (CoreIN_RESET)       chain_q <= '0;
        else if (se)            chain_q <= {chain_q[N-2:0], scan_out};
        else if (busy && !done) chain_q <= '0;
    end
    assign scan_in = chain_q[N-1];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Launches one operation and records what the DUT did over 14 cycles.
    task automatic run_op(input logic [7:0] pat, input logic cap,
                          input int glitch_cyc, input int rst_cyc,
                          output int busy_n, output int se_n, output int done_n,
                          output int done_at, output int cap_n,
                          output logic [7:0] sent, output logic [7:0] resp,
                          output logic p_se, output logic p_busy,
                          output logic [7:0] p_resp);
        busy_n = 0; se_n = 0; done_n = 0; done_at = 0; cap_n = 0;
        sent = '0; resp = 'x; p_se = 1'bx; p_busy = 1'bx; p_resp = 'x;
        pattern_in = pat; capture_en = cap; start = 1'b1;
        tick();
        start = 1'b0; pattern_in = '0; capture_en = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (busy) busy_n++;
            if (se) begin
                if (se_n < 8) sent[se_n[2:0]] = scan_out;
                se_n++;
            end
            if (busy && !se && !done) cap_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
                resp = response;
            end
            if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
                p_se = se; p_busy = busy; p_resp = response;
            end
            start        = (cyc == glitch_cyc);
            pattern_in   = (cyc == glitch_cyc) ? 8'h11 : 8'h00;
            CoreIN_RESET = (cyc == rst_cyc);
            tick();
        end
        start = 1'b0; CoreIN_RESET = 1'b0; pattern_in = '0;
    endtask

    task automatic test_reset();
        CoreIN_RESET = 1'b1; start = 1'b1; pattern_in = 8'hFF; capture_en = 1'b1;
        tick(); tick();
        chk_cnt++; if (se !== 1'b0) $display("FAIL reset_se got=%b exp=0", se); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        chk_cnt++; if (scan_out !== 1'b0) $display("FAIL reset_scan_out got=%b exp=0", scan_out); else pass_cnt++;
        chk_cnt++; if (response !== 8'h00) $display("FAIL reset_response got=%h exp=00", response); else pass_cnt++;
        CoreIN_RESET = 1'b0; start = 1'b0; pattern_in = '0; capture_en = 1'b0;
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        int b, s, d, da, c; logic [7:0] snt, r, ps, pr; logic pb, pse;
        run_op(8'hA5, 1'b0, 0, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (b != 9) $display("FAIL basic_busy_cycles got=%0d exp=9", b); else pass_cnt++;
        chk_cnt++; if (s != 8) $display("FAIL basic_se_cycles got=%0d exp=8", s); else pass_cnt++;
        chk_cnt++; if (da != 9) $display("FAIL basic_done_at got=%0d exp=9", da); else pass_cnt++;
        chk_cnt++; if (d != 1) $display("FAIL basic_done_count got=%0d exp=1", d); else pass_cnt++;
        chk_cnt++; if (snt !== 8'hA5) $display("FAIL basic_scan_out got=%h exp=a5", snt); else pass_cnt++;
        chk_cnt++; if (r !== 8'h00) $display("FAIL basic_response got=%h exp=00", r); else pass_cnt++;
        chk_cnt++; if (response !== 8'h00) $display("FAIL basic_resp_stable got=%h exp=00", response); else pass_cnt++;
        ps = '0;
    endtask

    task automatic test_second();
        int b, s, d, da, c; logic [7:0] snt, r, pr; logic pb, pse;
        run_op(8'h3C, 1'b0, 0, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (r !== 8'hA5) $display("FAIL second_response got=%h exp=a5", r); else pass_cnt++;
        chk_cnt++; if (snt !== 8'h3C) $display("FAIL second_scan_out got=%h exp=3c", snt); else pass_cnt++;
        chk_cnt++; if (c != 0) $display("FAIL second_no_capture got=%0d exp=0", c); else pass_cnt++;
    endtask

    task automatic test_capture();
        int b, s, d, da, c; logic [7:0] snt, r, pr; logic pb, pse;
        run_op(8'hFF, 1'b1, 0, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (c != 1) $display("FAIL capture_cycles got=%0d exp=1", c); else pass_cnt++;
        chk_cnt++; if (da != 10) $display("FAIL capture_done_at got=%0d exp=10", da); else pass_cnt++;
        chk_cnt++; if (b != 10) $display("FAIL capture_busy_cycles got=%0d exp=10", b); else pass_cnt++;
        chk_cnt++; if (s != 8) $display("FAIL capture_se_cycles got=%0d exp=8", s); else pass_cnt++;
        chk_cnt++; if (r !== 8'h3C) $display("FAIL capture_response got=%h exp=3c", r); else pass_cnt++;
        run_op(8'h00, 1'b0, 0, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (r !== 8'h00) $display("FAIL capture_unload got=%h exp=00", r); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int b, s, d, da, c; logic [7:0] snt, r, pr; logic pb, pse;
        run_op(8'h5A, 1'b0, 3, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (snt !== 8'h5A) $display("FAIL ignore_scan_out got=%h exp=5a", snt); else pass_cnt++;
        chk_cnt++; if (d != 1) $display("FAIL ignore_done_count got=%0d exp=1", d); else pass_cnt++;
        chk_cnt++; if (da != 9) $display("FAIL ignore_done_at got=%0d exp=9", da); else pass_cnt++;
        chk_cnt++; if (b != 9) $display("FAIL ignore_busy_cycles got=%0d exp=9", b); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int b, s, d, da, c; logic [7:0] snt, r, pr; logic pb, pse;
        run_op(8'hC3, 1'b0, 0, 4, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (pse !== 1'b0) $display("FAIL midrst_se got=%b exp=0", pse); else pass_cnt++;
        chk_cnt++; if (pb !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", pb); else pass_cnt++;
        chk_cnt++; if (pr !== 8'h00) $display("FAIL midrst_response got=%h exp=00", pr); else pass_cnt++;
        chk_cnt++; if (d != 0) $display("FAIL midrst_no_done got=%0d exp=0", d); else pass_cnt++;
        run_op(8'h96, 1'b0, 0, 0, b, s, d, da, c, snt, r, pse, pb, pr);
        chk_cnt++; if (da != 9) $display("FAIL midrst_next_done_at got=%0d exp=9", da); else pass_cnt++;
        chk_cnt++; if (snt !== 8'h96) $display("FAIL midrst_next_scan_out got=%h exp=96", snt); else pass_cnt++;
        chk_cnt++; if (r !== 8'h00) $display("FAIL midrst_next_response got=%h exp=00", r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int done_n = 0, idle_n = 0, run = 0, max_run = 0;
        logic [7:0] r [3];
        r[0] = 'x; r[1] = 'x; r[2] = 'x;
        start = 1'b1; pattern_in = 8'h69; capture_en = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (!busy) begin
                idle_n++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done) begin
                if (done_n < 3) r[done_n] = response;
                done_n++;
            end
        end
        start = 1'b0; pattern_in = '0;
        for (int i = 0; i < 12; i++) tick();
        chk_cnt++; if (done_n != 3) $display("FAIL b2b_done_count got=%0d exp=3", done_n); else pass_cnt++;
        chk_cnt++; if (idle_n != 3) $display("FAIL b2b_idle_cycles got=%0d exp=3", idle_n); else pass_cnt++;
        chk_cnt++; if (max_run != 1) $display("FAIL b2b_idle_gap got=%0d exp=1", max_run); else pass_cnt++;
        chk_cnt++; if (r[0] !== 8'h96) $display("FAIL b2b_resp0 got=%h exp=96", r[0]); else pass_cnt++;
        chk_cnt++; if (r[1] !== 8'h69) $display("FAIL b2b_resp1 got=%h exp=69", r[1]); else pass_cnt++;
        chk_cnt++; if (r[2] !== 8'h69) $display("FAIL b2b_resp2 got=%h exp=69", r[2]); else pass_cnt++;
    endtask

    initial begin
        CoreIN_RESET = 1'b1; start = 1'b0; capture_en = 1'b0; pattern_in = '0;
        test_reset();
        test_basic();
        test_second();
        test_capture();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
